// File: rtl/nic8_bus_pkg.sv
// Shared types for the nic8 memory-bus arbiter.
// State encoding and counter sizing helpers.
package nic8_bus_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        CPU     = 2'd0,
        HALTING = 2'd1,
        DMA     = 2'd2,
        RELEASE = 2'd3
    } busState_e;

    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX; synchronous clear wins over increment.
// Reset value is a parameter so a counter can start saturated.
module sat_counter #(
    parameter int WIDTH   = 4,
    parameter int MAX     = 15,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(RST_VAL);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= CNT_RST;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the CPU and a DMA requester.
// DMA bursts are bounded and separated by a CPU run-time floor.
module mem_bus_arbiter
    import nic8_bus_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = 16,
    parameter int CPU_MIN   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic          cpu_re,
    output logic          cpu_halt,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic          dma_last,
    output logic          dma_gnt,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = cntWidth(CPU_MIN);
    localparam int BW = cntWidth(MAX_BURST);

    busState_e     state;
    busState_e     stateNext;
    logic [CW-1:0] cpuCnt;
    logic [BW-1:0] burstCnt;
    logic          floorMet;
    logic          burstAtCap;
    logic          xfer;

    sat_counter #(
        .WIDTH  (CW),
        .MAX    (CPU_MIN),
        .RST_VAL(CPU_MIN)
    ) cpuCounter (
        .clk  (clk),
        .rstN (reset),
        .clear(state == RELEASE),
        .inc  (state == CPU),
        .count(cpuCnt)
    );

    sat_counter #(
        .WIDTH  (BW),
        .MAX    (MAX_BURST),
        .RST_VAL(0)
    ) burstCounter (
        .clk  (clk),
        .rstN (reset),
        .clear(state == HALTING),
        .inc  (xfer),
        .count(burstCnt)
    );

    // A zero floor would make the compare constant, so fold it away.
    generate
        if (CPU_MIN == 0) begin : gNoFloor
            assign floorMet = 1'b1;
        end else begin : gFloor
            assign floorMet = (cpuCnt >= CW'(CPU_MIN));
        end
    endgenerate

    assign burstAtCap = (burstCnt == BW'(MAX_BURST - 1));
    assign xfer       = (state == DMA) && dma_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CPU;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        cpu_halt  = 1'b1;
        dma_gnt   = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        unique case (state)
            CPU: begin
                cpu_halt = 1'b0;
                mem_we   = cpu_we;
                mem_re   = cpu_re;
                if (dma_req && floorMet) begin
                    stateNext = HALTING;
                end
            end
            HALTING: begin
                stateNext = DMA;
            end
            DMA: begin
                dma_gnt   = 1'b1;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_we    = dma_req & dma_we;
                mem_re    = dma_req & ~dma_we;
                // In DMA every cycle with dma_req is a transfer.
                if (!dma_req || dma_last || burstAtCap) begin
                    stateNext = RELEASE;
                end
            end
            RELEASE: begin
                stateNext = CPU;
            end
            default: begin
                stateNext = CPU;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= xfer && !dma_we;
            if (xfer && !dma_we) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

endmodule
